dsi_lanes_distributor: RTL and testbench

- Upstream neighbour of the DSI lanes controller: converts a 32-bit packet byte stream into per-lane 9-bit entries ({lp, byte}).
- Spreads HS bytes round-robin across the active lanes (1..4); LP packets go to lane 0 only.
- Buffers each lane in its own show-ahead FIFO, which the lane bridges drain through lanes_fifo_read.

---
 rtl/dsi_pkg.sv | 28 ++
 rtl/dsi_lane_byte_fifo.sv | 50 +++++
 rtl/dsi_lanes_distributor.sv | 154 +++++++++++++++
 tb/tb_dsi_lanes_distributor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI lane distributor and its per-lane FIFOs.
package dsi_pkg;

    localparam int unsigned LANES_MAX    = 4;
    localparam int unsigned LANE_ENTRY_W = 9;

    typedef struct packed {
        logic       lp;
        logic [7:0] data;
    } lane_entry_t;

    // Lane count register to effective lane count: 0 -> 1, above 4 -> 4.
    function automatic logic [2:0] clamp_lanes(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd4)  return 3'd4;
        return n;
    endfunction

    // Number of leading ones in the byte-enable mask.
    function automatic logic [2:0] strb_nbytes(input logic [3:0] strb);
        if (!strb[0]) return 3'd0;
        if (!strb[1]) return 3'd1;
        if (!strb[2]) return 3'd2;
        if (!strb[3]) return 3'd3;
        return 3'd4;
    endfunction

endpackage

// File: rtl/dsi_lane_byte_fifo.sv
// Show-ahead FIFO of {lp, byte} lane entries; head is presented whenever non-empty.
module dsi_lane_byte_fifo
    import dsi_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  lane_entry_t din,
    input  logic        pop,
    output lane_entry_t dout,
    output logic        empty,
    output logic        full
);

    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    lane_entry_t      mem_q [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
        // Full comes from the current pointers, so a pop does not free a slot for a same-cycle push.
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + (FIFO_AW+1)'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + (FIFO_AW+1)'(1) : rptr_q;
        dout    = empty ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/dsi_lanes_distributor.sv
// Splits a 32-bit packet byte stream round-robin over 1..4 DSI lanes (LP packets on
// lane 0 only) and buffers each lane in its own show-ahead FIFO.
module dsi_lanes_distributor
    import dsi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk_phy,
    input  logic                              rst_n,
    input  logic                              dist_enable,
    input  logic [2:0]                        reg_lanes_number,
    input  logic                              pkt_valid,
    output logic                              pkt_ready,
    input  logic [31:0]                       pkt_data,
    input  logic [3:0]                        pkt_strb,
    input  logic                              pkt_lp,
    input  logic                              pkt_last,
    output logic [LANES_MAX*LANE_ENTRY_W-1:0] lanes_fifo_data,
    output logic [LANES_MAX-1:0]              lanes_fifo_empty,
    input  logic [LANES_MAX-1:0]              lanes_fifo_read,
    output logic [LANES_MAX-1:0]              lanes_fifo_full,
    output logic                              busy
);

    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [2:0]  hold_nbytes_q, hold_nbytes_d;
    logic        hold_last_q, hold_last_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [1:0]  lane_ptr_q, lane_ptr_d;
    logic        in_packet_q, in_packet_d;
    logic [2:0]  n_eff_q, n_eff_d;
    logic        lp_lat_q, lp_lat_d;
    logic        ready_en_q;

    logic [2:0]           rem, k, tgt, ptr_sum;
    logic [1:0]           bsel;
    logic [LANES_MAX-1:0] lane_wr, lane_push, lane_full, lane_empty;
    lane_entry_t          lane_din  [LANES_MAX];
    lane_entry_t          lane_dout [LANES_MAX];
    logic                 fire, done, accept;

    always_comb begin
        rem     = hold_nbytes_q - bidx_q;
        k       = (rem < n_eff_q) ? rem : n_eff_q;
        tgt     = '0;
        bsel    = '0;
        lane_wr = '0;
        for (int unsigned l = 0; l < LANES_MAX; l++) lane_din[l] = '0;
        // lane_ptr < n_eff and j < n_eff, so one conditional subtract is a full modulo.
        for (int unsigned j = 0; j < LANES_MAX; j++) begin
            if (hold_valid_q && (3'(j) < k)) begin
                tgt = {1'b0, lane_ptr_q} + 3'(j);
                if (tgt >= n_eff_q) tgt = tgt - n_eff_q;
                bsel = 2'(bidx_q + 3'(j));
                lane_wr[tgt[1:0]]       = 1'b1;
                lane_din[tgt[1:0]].lp   = lp_lat_q;
                lane_din[tgt[1:0]].data = hold_data_q[{bsel, 3'b000} +: 8];
            end
        end
        fire      = hold_valid_q && ((lane_wr & lane_full) == '0);
        done      = ((bidx_q + k) == hold_nbytes_q);
        lane_push = fire ? lane_wr : '0;
        pkt_ready = ready_en_q && dist_enable && (!hold_valid_q || (fire && done));
        accept    = pkt_valid && pkt_ready;
        busy      = hold_valid_q || (lane_empty != '1);
    end

    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        hold_nbytes_d = hold_nbytes_q;
        hold_last_d   = hold_last_q;
        bidx_d        = bidx_q;
        lane_ptr_d    = lane_ptr_q;
        in_packet_d   = in_packet_q;
        n_eff_d       = n_eff_q;
        lp_lat_d      = lp_lat_q;
        ptr_sum       = {1'b0, lane_ptr_q} + k;
        if (ptr_sum >= n_eff_q) ptr_sum = ptr_sum - n_eff_q;
        if (fire) begin
            bidx_d     = bidx_q + k;
            lane_ptr_d = ptr_sum[1:0];
            if (done) begin
                hold_valid_d = 1'b0;
                if (hold_last_q) begin
                    lane_ptr_d  = '0;
                    in_packet_d = 1'b0;
                end
            end
        end
        // Accept is applied after retirement so a back-to-back beat sees the packet boundary.
        if (accept) begin
            hold_data_d   = pkt_data;
            hold_nbytes_d = strb_nbytes(pkt_strb);
            hold_last_d   = pkt_last;
            hold_valid_d  = 1'b1;
            bidx_d        = '0;
            if (!in_packet_d) begin
                n_eff_d     = pkt_lp ? 3'd1 : clamp_lanes(reg_lanes_number);
                lp_lat_d    = pkt_lp;
                in_packet_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_phy or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            hold_nbytes_q <= '0;
            hold_last_q   <= 1'b0;
            bidx_q        <= '0;
            lane_ptr_q    <= '0;
            in_packet_q   <= 1'b0;
            n_eff_q       <= 3'd1;
            lp_lat_q      <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            hold_nbytes_q <= hold_nbytes_d;
            hold_last_q   <= hold_last_d;
            bidx_q        <= bidx_d;
            lane_ptr_q    <= lane_ptr_d;
            in_packet_q   <= in_packet_d;
            n_eff_q       <= n_eff_d;
            lp_lat_q      <= lp_lat_d;
            ready_en_q    <= 1'b1;
        end
    end

    for (genvar i = 0; i < LANES_MAX; i++) begin : g_lane
        dsi_lane_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk_phy),
            .rst_n (rst_n),
            .push  (lane_push[i]),
            .din   (lane_din[i]),
            .pop   (lanes_fifo_read[i]),
            .dout  (lane_dout[i]),
            .empty (lane_empty[i]),
            .full  (lane_full[i])
        );
    end

    always_comb begin
        lanes_fifo_data  = '0;
        for (int unsigned i = 0; i < LANES_MAX; i++)
            lanes_fifo_data[i*LANE_ENTRY_W +: LANE_ENTRY_W] = lane_dout[i];
        lanes_fifo_empty = lane_empty;
        lanes_fifo_full  = lane_full;
    end

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Directed bench for dsi_lanes_distributor: per-scenario tasks with hand-computed lane contents.
module tb_dsi_lanes_distributor;

    logic        clk_phy = 1'b0;
    logic        rst_n;
    logic        dist_enable;
    logic [2:0]  reg_lanes_number;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_strb;
    logic        pkt_lp;
    logic        pkt_last;
    logic [35:0] lanes_fifo_data;
    logic [3:0]  lanes_fifo_empty;
    logic [3:0]  lanes_fifo_read;
    logic [3:0]  lanes_fifo_full;
    logic        busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk_phy = ~clk_phy;

    dsi_lanes_distributor #(.FIFO_DEPTH(16)) dut (
        .clk_phy          (clk_phy),
        .rst_n            (rst_n),
        .dist_enable      (dist_enable),
        .reg_lanes_number (reg_lanes_number),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_data         (pkt_data),
        .pkt_strb         (pkt_strb),
        .pkt_lp           (pkt_lp),
        .pkt_last         (pkt_last),
        .lanes_fifo_data  (lanes_fifo_data),
        .lanes_fifo_empty (lanes_fifo_empty),
        .lanes_fifo_read  (lanes_fifo_read),
        .lanes_fifo_full  (lanes_fifo_full),
        .busy             (busy)
    );

    task automatic step();
        @(negedge clk_phy);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic lp, input logic last);
        bit ok;
        ok = 1'b0;
        pkt_data = d; pkt_strb = s; pkt_lp = lp; pkt_last = last; pkt_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (pkt_ready === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        if (ok) step();
        pkt_valid = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_accept data=%h: pkt_ready never seen in 200 cycles, required acceptance", d);
        end
    endtask

    task automatic pop(input int unsigned lane, output logic [8:0] val, output logic emp);
        emp = lanes_fifo_empty[lane];
        val = lanes_fifo_data[lane*9 +: 9];
        lanes_fifo_read[lane] = 1'b1;
        step();
        lanes_fifo_read[lane] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++; if (pkt_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b expected=0", pkt_ready); end
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL reset_empty got=%h expected=f", lanes_fifo_empty); end
        vectors++; if (lanes_fifo_full !== 4'h0) begin miscompares++; $display("FAIL reset_full got=%h expected=0", lanes_fifo_full); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b expected=0", busy); end
        vectors++; if (lanes_fifo_data !== 36'h0) begin miscompares++; $display("FAIL reset_data got=%h expected=0", lanes_fifo_data); end
        rst_n = 1'b1;
        step(); step();
        dist_enable = 1'b0; #1;
        vectors++; if (pkt_ready !== 1'b0) begin miscompares++; $display("FAIL disabled_ready got=%b expected=0", pkt_ready); end
        dist_enable = 1'b1; #1;
        vectors++; if (pkt_ready !== 1'b1) begin miscompares++; $display("FAIL enabled_ready got=%b expected=1", pkt_ready); end
    endtask

    task automatic test_hs_four_lanes();
        logic [8:0] v; logic e;
        reg_lanes_number = 3'd4;
        send(32'h44332211, 4'hF, 1'b0, 1'b1);
        step();
        vectors++; if (lanes_fifo_empty !== 4'h0) begin miscompares++; $display("FAIL t1_single_fire empty got=%h expected=0", lanes_fifo_empty); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy got=%b expected=1", busy); end
        for (int unsigned l = 0; l < 4; l++) begin
            pop(l, v, e);
            vectors++;
            if (e !== 1'b0 || v !== 9'((l+1)*17)) begin
                miscompares++; $display("FAIL t1_lane%0d got empty=%b data=%h expected data=%h", l, e, v, 9'((l+1)*17));
            end
        end
        vectors++; if (lanes_fifo_empty !== 4'hF || busy !== 1'b0) begin miscompares++; $display("FAIL t1_drained empty=%h busy=%b expected f/0", lanes_fifo_empty, busy); end
    endtask

    task automatic test_two_lanes();
        logic [8:0] v; logic e;
        logic [8:0] e0 [3];
        logic [8:0] e1 [2];
        e0 = '{9'h0AA, 9'h0CC, 9'h0EE};
        e1 = '{9'h0BB, 9'h0DD};
        reg_lanes_number = 3'd2;
        send(32'hDDCCBBAA, 4'hF, 1'b0, 1'b0);
        pkt_data = 32'h000000EE; pkt_strb = 4'h1; pkt_last = 1'b1; pkt_valid = 1'b1;
        #1;
        vectors++; if (pkt_ready !== 1'b0) begin miscompares++; $display("FAIL t2_ready_low got=%b expected=0", pkt_ready); end
        step();
        vectors++; if (pkt_ready !== 1'b1) begin miscompares++; $display("FAIL t2_ready_high got=%b expected=1", pkt_ready); end
        step();
        pkt_valid = 1'b0;
        step(); step();
        vectors++; if (lanes_fifo_empty !== 4'b1100) begin miscompares++; $display("FAIL t2_empty got=%b expected=1100", lanes_fifo_empty); end
        for (int unsigned i = 0; i < 3; i++) begin
            pop(0, v, e); vectors++;
            if (e !== 1'b0 || v !== e0[i]) begin miscompares++; $display("FAIL t2_lane0_%0d got empty=%b data=%h expected=%h", i, e, v, e0[i]); end
        end
        for (int unsigned i = 0; i < 2; i++) begin
            pop(1, v, e); vectors++;
            if (e !== 1'b0 || v !== e1[i]) begin miscompares++; $display("FAIL t2_lane1_%0d got empty=%b data=%h expected=%h", i, e, v, e1[i]); end
        end
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL t2_drained got=%h expected=f", lanes_fifo_empty); end
    endtask

    task automatic test_lp_packet();
        logic [8:0] v; logic e;
        reg_lanes_number = 3'd4;
        send(32'h04030201, 4'hF, 1'b1, 1'b0);
        send(32'h00000005, 4'h1, 1'b0, 1'b1);
        repeat (6) step();
        vectors++; if (lanes_fifo_empty !== 4'b1110) begin miscompares++; $display("FAIL t3_empty got=%b expected=1110", lanes_fifo_empty); end
        for (int unsigned i = 0; i < 5; i++) begin
            pop(0, v, e); vectors++;
            if (e !== 1'b0 || v !== 9'(9'h101 + i)) begin miscompares++; $display("FAIL t3_lane0_%0d got empty=%b data=%h expected=%h", i, e, v, 9'(9'h101 + i)); end
        end
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL t3_drained got=%h expected=f", lanes_fifo_empty); end
    endtask

    task automatic test_stall_full();
        logic [8:0] v; logic e;
        reg_lanes_number = 3'd2;
        lanes_fifo_read[0] = 1'b1;
        for (int i = 0; i < 8; i++)
            send({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, 1'b0, i == 7);
        repeat (4) step();
        lanes_fifo_read[0] = 1'b0;
        step();
        vectors++; if (lanes_fifo_full !== 4'b0010) begin miscompares++; $display("FAIL t4_full got=%b expected=0010", lanes_fifo_full); end
        reg_lanes_number = 3'd3;
        send(32'h44332211, 4'hF, 1'b0, 1'b1);
        step(); step();
        vectors++; if (pkt_ready !== 1'b0) begin miscompares++; $display("FAIL t4_stall_ready got=%b expected=0", pkt_ready); end
        vectors++; if (lanes_fifo_empty !== 4'b1101) begin miscompares++; $display("FAIL t4_stall_empty got=%b expected=1101", lanes_fifo_empty); end
        pop(1, v, e); vectors++;
        if (e !== 1'b0 || v !== 9'h001) begin miscompares++; $display("FAIL t4_unblock_pop got empty=%b data=%h expected=001", e, v); end
        repeat (3) step();
        vectors++; if (lanes_fifo_empty !== 4'b1000) begin miscompares++; $display("FAIL t4_resume_empty got=%b expected=1000", lanes_fifo_empty); end
        pop(0, v, e); vectors++;
        if (e !== 1'b0 || v !== 9'h011) begin miscompares++; $display("FAIL t4_lane0_b0 got empty=%b data=%h expected=011", e, v); end
        pop(0, v, e); vectors++;
        if (e !== 1'b0 || v !== 9'h044) begin miscompares++; $display("FAIL t4_lane0_b3 got empty=%b data=%h expected=044", e, v); end
        pop(2, v, e); vectors++;
        if (e !== 1'b0 || v !== 9'h033) begin miscompares++; $display("FAIL t4_lane2_b2 got empty=%b data=%h expected=033", e, v); end
        for (int unsigned i = 1; i < 16; i++) begin
            pop(1, v, e); vectors++;
            if (e !== 1'b0 || v !== 9'(2*i+1)) begin miscompares++; $display("FAIL t4_lane1_fill%0d got empty=%b data=%h expected=%h", i, e, v, 9'(2*i+1)); end
        end
        pop(1, v, e); vectors++;
        if (e !== 1'b0 || v !== 9'h022) begin miscompares++; $display("FAIL t4_lane1_b1 got empty=%b data=%h expected=022", e, v); end
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL t4_drained got=%h expected=f", lanes_fifo_empty); end
    endtask

    task automatic test_lane_count_change();
        logic [8:0] v; logic e;
        logic [8:0] e0 [4];
        e0 = '{9'h011, 9'h055, 9'h0AA, 9'h0BB};
        reg_lanes_number = 3'd4;
        send(32'h44332211, 4'hF, 1'b0, 1'b0);
        reg_lanes_number = 3'd1;
        send(32'h88776655, 4'hF, 1'b0, 1'b1);
        send(32'h0000BBAA, 4'h3, 1'b0, 1'b1);
        repeat (4) step();
        for (int unsigned i = 0; i < 4; i++) begin
            pop(0, v, e); vectors++;
            if (e !== 1'b0 || v !== e0[i]) begin miscompares++; $display("FAIL t5_lane0_%0d got empty=%b data=%h expected=%h", i, e, v, e0[i]); end
        end
        for (int unsigned l = 1; l < 4; l++) begin
            for (int unsigned i = 0; i < 2; i++) begin
                pop(l, v, e); vectors++;
                if (e !== 1'b0 || v !== 9'((l+1+4*i)*17)) begin
                    miscompares++; $display("FAIL t5_lane%0d_%0d got empty=%b data=%h expected=%h", l, i, e, v, 9'((l+1+4*i)*17));
                end
            end
        end
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL t5_drained got=%h expected=f", lanes_fifo_empty); end
        reg_lanes_number = 3'd0;
        send(32'h00002211, 4'h3, 1'b0, 1'b1);
        repeat (4) step();
        vectors++; if (lanes_fifo_empty !== 4'b1110) begin miscompares++; $display("FAIL t5_n0_empty got=%b expected=1110", lanes_fifo_empty); end
        for (int unsigned i = 0; i < 2; i++) begin
            pop(0, v, e); vectors++;
            if (e !== 1'b0 || v !== 9'((i+1)*17)) begin miscompares++; $display("FAIL t5_n0_lane0_%0d got empty=%b data=%h expected=%h", i, e, v, 9'((i+1)*17)); end
        end
        reg_lanes_number = 3'd7;
        send(32'h44332211, 4'hF, 1'b0, 1'b1);
        repeat (3) step();
        vectors++; if (lanes_fifo_empty !== 4'h0) begin miscompares++; $display("FAIL t5_n7_empty got=%b expected=0000", lanes_fifo_empty); end
        for (int unsigned l = 0; l < 4; l++) begin
            pop(l, v, e); vectors++;
            if (e !== 1'b0 || v !== 9'((l+1)*17)) begin miscompares++; $display("FAIL t5_n7_lane%0d got empty=%b data=%h expected=%h", l, e, v, 9'((l+1)*17)); end
        end
    endtask

    task automatic test_reset_midpacket();
        logic [8:0] v; logic e;
        reg_lanes_number = 3'd4;
        send(32'h000000AA, 4'h1, 1'b0, 1'b0);
        send(32'h44332211, 4'hF, 1'b0, 1'b0);
        vectors++; if (busy !== 1'b1 || lanes_fifo_empty !== 4'b1110) begin miscompares++; $display("FAIL t6_pre busy=%b empty=%b expected 1/1110", busy, lanes_fifo_empty); end
        rst_n = 1'b0;
        #1;
        vectors++; if (lanes_fifo_empty !== 4'hF) begin miscompares++; $display("FAIL t6_empty got=%h expected=f", lanes_fifo_empty); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy got=%b expected=0", busy); end
        vectors++; if (pkt_ready !== 1'b0) begin miscompares++; $display("FAIL t6_ready got=%b expected=0", pkt_ready); end
        vectors++; if (lanes_fifo_data !== 36'h0) begin miscompares++; $display("FAIL t6_data got=%h expected=0", lanes_fifo_data); end
        step();
        rst_n = 1'b1;
        step(); step();
        send(32'hD4C3B2A1, 4'hF, 1'b0, 1'b1);
        repeat (3) step();
        vectors++; if (lanes_fifo_empty !== 4'h0) begin miscompares++; $display("FAIL t6_after_empty got=%b expected=0000", lanes_fifo_empty); end
        for (int unsigned l = 0; l < 4; l++) begin
            pop(l, v, e); vectors++;
            if (e !== 1'b0 || v !== 9'(9'h0A1 + 17*l)) begin miscompares++; $display("FAIL t6_lane%0d got empty=%b data=%h expected=%h", l, e, v, 9'(9'h0A1 + 17*l)); end
        end
        vectors++; if (lanes_fifo_empty !== 4'hF || busy !== 1'b0) begin miscompares++; $display("FAIL t6_drained empty=%h busy=%b expected f/0", lanes_fifo_empty, busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; dist_enable = 1'b1; reg_lanes_number = 3'd1;
        pkt_valid = 1'b0; pkt_data = '0; pkt_strb = '0; pkt_lp = 1'b0; pkt_last = 1'b0;
        lanes_fifo_read = '0;
        test_reset();
        test_hs_four_lanes();
        test_two_lanes();
        test_lp_packet();
        test_stall_full();
        test_lane_count_change();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
